ext_pipe: RTL

- Parametrised, pipelined immediate extender for the datapath.
- Accepts an immediate plus an extension opcode over a valid/ready handshake and returns the widened value two cycles later.
- Supports sign, zero, upper-half placement and shifted-sign/shifted-zero extension.
- Sits between decode and the ALU operand mux. Supports stalls through full backpressure and keeps a completed-transfer counter for debug.

---
 rtl/ext_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: two-stage immediate extender with valid/ready handshake.
// S1 captures the raw immediate and mode. S2 holds the widened result.
// The pipeline carries one beat per cycle and tolerates full backpressure.
// cnt counts completed output transfers and wraps.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [2:0]       EOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] ext,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt
);

    localparam int P = OUT_W - IN_W;

    typedef enum logic [2:0] {
        EOP_SIGN   = 3'b000,
        EOP_ZERO   = 3'b001,
        EOP_UPPER  = 3'b010,
        EOP_SSHIFT = 3'b011,
        EOP_ZSHIFT = 3'b100
    } eop_e;

    // Parameter sanity: an illegal combination is reported during elaboration.
    if (IN_W >= OUT_W) begin : g_bad_width
        $error("ext_pipe: IN_W (%0d) must be smaller than OUT_W (%0d)", IN_W, OUT_W);
    end
    if (SHIFT > OUT_W - IN_W) begin : g_bad_shift
        $error("ext_pipe: SHIFT (%0d) exceeds OUT_W-IN_W (%0d)", SHIFT, OUT_W - IN_W);
    end

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
    eop_e             s1_eop_q, s1_eop_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] ext_q, ext_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load;
    logic             accept;
    logic             xfer;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] ext_calc;
    logic             err_calc;

    // Widen the S1 immediate according to its mode; unknown modes yield zero plus error.
    always_comb begin
        sext     = {{P{s1_imm_q[IN_W-1]}}, s1_imm_q};
        zext     = {{P{1'b0}}, s1_imm_q};
        ext_calc = '0;
        err_calc = 1'b0;
        case (s1_eop_q)
            EOP_SIGN:   ext_calc = sext;
            EOP_ZERO:   ext_calc = zext;
            EOP_UPPER:  ext_calc = {s1_imm_q, {P{1'b0}}};
            EOP_SSHIFT: ext_calc = sext << SHIFT;
            EOP_ZSHIFT: ext_calc = zext << SHIFT;
            default:    err_calc = 1'b1;
        endcase
    end

    // Handshake and stage-advance logic; in_ready depends on out_ready but never on in_valid.
    always_comb begin
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready   = !s1_valid_q || s2_load;
        accept     = in_valid && in_ready;
        xfer       = s2_valid_q && out_ready;

        s1_valid_d = accept || (s1_valid_q && !s2_load);
        s1_imm_d   = s1_imm_q;
        s1_eop_d   = s1_eop_q;
        if (accept) begin
            s1_imm_d = imm;
            s1_eop_d = eop_e'(EOp);
        end

        s2_valid_d = s2_load || (s2_valid_q && !out_ready);
        ext_d      = ext_q;
        err_d      = err_q;
        if (s2_load) begin
            ext_d = ext_calc;
            err_d = err_calc;
        end

        cnt_d = cnt_q + CNT_W'(xfer);
    end

    // Pipeline and counter registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_eop_q   <= EOP_SIGN;
            s2_valid_q <= 1'b0;
            ext_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_eop_q   <= s1_eop_d;
            s2_valid_q <= s2_valid_d;
            ext_q      <= ext_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign ext       = ext_q;
    assign out_err   = err_q;
    assign cnt       = cnt_q;

endmodule
